// File: rtl/aud_stream_buf_pkg.sv
// Shared types and defaults for the audio stream buffer (package aud_pkg).
package aud_pkg;
  localparam int AUD_DATA_W     = 16;
  localparam int AUD_CHANNELS   = 2;
  localparam int AUD_DEPTH      = 512;
  localparam int AUD_BLK_WORDS  = 128;
  localparam int AUD_UNDERRUN_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    ISSUE,
    WAIT_BSY,
    WAIT_DONE
  } aud_state_t;
endpackage

// File: rtl/aud_stream_buf_if.sv
// Sample path between storage engine, buffer and I2S transmitter.
// Write side: in_wr is a level held by the source until a one-cycle in_fin; a word is
// taken at most once per in_wr assertion. Read side: out_rd with out_vld pops one word,
// and out_dat shows that word from the following cycle until the next pop.
interface aud_stream_buf_if #(
  parameter int W = 32
);
  logic         in_wr;
  logic         in_fin;
  logic [W-1:0] in_dat;
  logic         out_rd;
  logic         out_vld;
  logic [W-1:0] out_dat;

  modport master (
    output in_wr, in_dat, out_rd,
    input  in_fin, out_vld, out_dat
  );

  modport slave (
    input  in_wr, in_dat, out_rd,
    output in_fin, out_vld, out_dat
  );
endinterface

// File: rtl/aud_sdp_ram.sv
// Simple dual-port RAM: synchronous write, registered read with clearable output.
module aud_sdp_ram #(
  parameter int W     = 32,
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  input  logic          rclr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register only; the array itself has no reset so it maps to block RAM.
  always_ff @(posedge clk) begin
    if (rst || rclr) rdata <= '0;
    else if (re)     rdata <= mem[raddr];
  end
endmodule

// File: rtl/aud_stream_buf.sv
// Audio sample buffer with autonomous block-read refill engine.
// Optional AUD_UNDERRUN_MUTE_EN: a read while empty zeroes out_dat instead of holding it.
module aud_stream_buf
  import aud_pkg::*;
#(
  parameter int DATA_W    = AUD_DATA_W,
  parameter int CHANNELS  = AUD_CHANNELS,
  parameter int DEPTH     = AUD_DEPTH,
  parameter int BLK_WORDS = AUD_BLK_WORDS,
  parameter int W         = DATA_W * CHANNELS,
  parameter int AW        = $clog2(DEPTH),
  parameter int LW        = AW + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [31:0]               start_addr,
  aud_stream_buf_if.slave           io,
  output logic [LW-1:0]             level,
  output logic                      refill_issue,
  output logic [31:0]               refill_addr,
  input  logic                      refill_busy,
  output logic [AUD_UNDERRUN_W-1:0] underrun_cnt,
  output aud_state_t                state_dbg
);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_q, free_words;
  logic          fin_q, wr_acc, pop, underrun, rd_clr;
  logic          en_q;
  aud_state_t    state, state_nxt;

  // in_fin blocks a second accept of the same held request.
  assign wr_acc     = io.in_wr && (level_q != LW'(DEPTH)) && !fin_q;
  assign pop        = io.out_rd && (level_q != '0);
  assign underrun   = io.out_rd && (level_q == '0);
  assign free_words = LW'(DEPTH) - level_q;

`ifdef AUD_UNDERRUN_MUTE_EN
  assign rd_clr = underrun;
`else
  assign rd_clr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level_q      <= '0;
      fin_q        <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      fin_q <= wr_acc;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (underrun && (underrun_cnt != '1)) underrun_cnt <= underrun_cnt + 1'b1;
    end
  end

  aud_sdp_ram #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (io.in_dat),
    .re    (pop),
    .raddr (rd_ptr),
    .rclr  (rd_clr),
    .rdata (io.out_dat)
  );

  assign io.in_fin  = fin_q;
  assign io.out_vld = (level_q != '0);
  assign level      = level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      en_q        <= 1'b0;
      refill_addr <= '0;
    end else begin
      state <= state_nxt;
      en_q  <= enable;
      if ((state == IDLE) && enable && !en_q)
        refill_addr <= start_addr;
      else if ((state == WAIT_DONE) && !refill_busy)
        refill_addr <= refill_addr + 32'd1;
    end
  end

  // A block in flight always completes; a dropped enable is honoured afterwards.
  always_comb begin
    state_nxt    = state;
    refill_issue = 1'b0;
    case (state)
      IDLE:      if (enable && !en_q) state_nxt = ARM;
      ARM: begin
        if (!enable) state_nxt = IDLE;
        else if ((free_words >= LW'(BLK_WORDS)) && !refill_busy) state_nxt = ISSUE;
      end
      ISSUE: begin
        refill_issue = 1'b1;
        state_nxt    = WAIT_BSY;
      end
      WAIT_BSY:  if (refill_busy) state_nxt = WAIT_DONE;
      WAIT_DONE: if (!refill_busy) state_nxt = enable ? ARM : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  assign state_dbg = state;
endmodule
